synaptic_update_sequencer: RTL and testbench

//  Sequencer/arbiter for synaptic_core's shared single-port weight and gradient SRAMs.
//  - On a training update request, walks every (pre neuron, post word) pair with a

---
 rtl/snn_ff_pkg.sv | 19 +
 rtl/synaptic_update_sequencer.sv | 130 +++++++++++++
 tb/tb_synaptic_update_sequencer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/snn_ff_pkg.sv
// Shared types and sizing helpers for the synaptic update path.
package snn_ff_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPreFetch,
        StUpdRd,
        StUpdWr,
        StDone
    } upd_state_t;

    function automatic int unsigned words_per_pre(input int unsigned n_out,
                                                  input int unsigned n_par);
        return n_out / n_par;
    endfunction

    localparam int unsigned W = words_per_pre(256, 4);

endpackage

// File: rtl/synaptic_update_sequencer.sv
// Arbitrates the shared weight/gradient SRAMs between full training sweeps (read-then-write
// per word) and idle-time inference reads.
module synaptic_update_sequencer
    import snn_ff_pkg::*;
#(
    parameter int unsigned INPUT_NEURON              = 784,
    parameter int unsigned OUTPUT_NEURON             = 256,
    parameter int unsigned POST_NEUR_PARALLEL        = 4,
    parameter int unsigned PRE_NEUR_ADDR_WIDTH       = 10,
    parameter int unsigned POST_NEUR_WORD_ADDR_WIDTH = 8,
    parameter int unsigned SYN_ARRAY_ADDR_WIDTH      = 16
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic                                 i_is_train,
    input  logic                                 i_start_update,
    input  logic                                 i_inf_req,
    input  logic [SYN_ARRAY_ADDR_WIDTH-1:0]      i_inf_addr,
    output logic                                 o_inf_gnt,
    output logic                                 o_ctrl_synarray_cs,
    output logic                                 o_ctrl_synarray_we,
    output logic [SYN_ARRAY_ADDR_WIDTH-1:0]      o_ctrl_synarray_addr,
    output logic                                 o_ctrl_grad_array_cs,
    output logic                                 o_ctrl_grad_array_we,
    output logic [PRE_NEUR_ADDR_WIDTH-1:0]       o_ctrl_pre_neur_addr,
    output logic [POST_NEUR_WORD_ADDR_WIDTH-1:0] o_ctrl_post_neur_word_addr,
    output logic                                 o_busy,
    output logic                                 o_update_done
);

    localparam int unsigned WORDS = words_per_pre(OUTPUT_NEURON, POST_NEUR_PARALLEL);
    localparam logic [POST_NEUR_WORD_ADDR_WIDTH-1:0] LAST_POST =
        POST_NEUR_WORD_ADDR_WIDTH'(WORDS - 1);
    localparam logic [PRE_NEUR_ADDR_WIDTH-1:0] LAST_PRE =
        PRE_NEUR_ADDR_WIDTH'(INPUT_NEURON - 1);

    upd_state_t                           r_state;
    logic                                 r_cs;
    logic                                 r_we;
    logic [SYN_ARRAY_ADDR_WIDTH-1:0]      r_addr;
    logic [PRE_NEUR_ADDR_WIDTH-1:0]       r_pre_cnt;
    logic [POST_NEUR_WORD_ADDR_WIDTH-1:0] r_post_cnt;
    logic                                 r_busy;
    logic                                 r_done;

    logic w_idle;
    logic w_start;
    logic w_inf_gnt;

    assign w_idle    = (r_state == StIdle);
    assign w_start   = w_idle & i_start_update & i_is_train;
    // A sweep start takes priority over a same-cycle inference request.
    assign w_inf_gnt = w_idle & ~i_rst & i_inf_req & ~w_start;

    assign o_inf_gnt                  = w_inf_gnt;
    assign o_ctrl_synarray_cs         = w_idle ? w_inf_gnt : r_cs;
    assign o_ctrl_synarray_we         = w_idle ? 1'b0 : r_we;
    assign o_ctrl_synarray_addr       = (w_idle & ~i_rst) ? i_inf_addr : r_addr;
    assign o_ctrl_grad_array_cs       = r_cs;
    assign o_ctrl_grad_array_we       = r_we;
    assign o_ctrl_pre_neur_addr       = r_pre_cnt;
    assign o_ctrl_post_neur_word_addr = r_post_cnt;
    assign o_busy                     = r_busy;
    assign o_update_done              = r_done;

    // Outputs are loaded on entry to each state, so they are valid for the whole state cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= StIdle;
            r_cs       <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_pre_cnt  <= '0;
            r_post_cnt <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_start) begin
                        r_state    <= StPreFetch;
                        r_cs       <= 1'b0;
                        r_we       <= 1'b0;
                        r_addr     <= '0;
                        r_pre_cnt  <= '0;
                        r_post_cnt <= '0;
                        r_busy     <= 1'b1;
                    end
                end
                StPreFetch: begin
                    r_state <= StUpdRd;
                    r_cs    <= 1'b1;
                    r_we    <= 1'b0;
                end
                StUpdRd: begin
                    r_state <= StUpdWr;
                    r_we    <= 1'b1;
                end
                StUpdWr: begin
                    // Running address counter stands in for pre_cnt*W + post_cnt.
                    r_addr <= r_addr + 1'b1;
                    r_we   <= 1'b0;
                    if (r_post_cnt == LAST_POST) begin
                        r_post_cnt <= '0;
                        r_cs       <= 1'b0;
                        if (r_pre_cnt == LAST_PRE) begin
                            r_state <= StDone;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_pre_cnt <= r_pre_cnt + 1'b1;
                            r_state   <= StPreFetch;
                        end
                    end else begin
                        r_post_cnt <= r_post_cnt + 1'b1;
                        r_state    <= StUpdRd;
                    end
                end
                StDone: begin
                    r_done  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_synaptic_update_sequencer.sv
// Directed/randomized bench for synaptic_update_sequencer at a reduced 3x8 array (W=2),
// with a word-level SRAM and update model.
module tb_synaptic_update_sequencer;

    localparam int N     = 3;
    localparam int NOUT  = 8;
    localparam int PAR   = 4;
    localparam int WPP   = NOUT / PAR;
    localparam int WORDS = N * WPP;

    logic        clk = 1'b0;
    logic        rst;
    logic        is_train;
    logic        start;
    logic        inf_req;
    logic [15:0] inf_addr;
    logic        inf_gnt;
    logic        syn_cs;
    logic        syn_we;
    logic [15:0] syn_addr;
    logic        grad_cs;
    logic        grad_we;
    logic [9:0]  pre_addr;
    logic [7:0]  post_addr;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic [15:0] salt;
    logic [15:0] mem [WORDS];
    int          wr_cnt [WORDS];

    typedef struct {
        int kind;   // 0 prefetch, 1 read, 2 write, 3 done
        int addr;
        int pre;
        int post;
    } step_t;

    synaptic_update_sequencer #(
        .INPUT_NEURON(N),
        .OUTPUT_NEURON(NOUT),
        .POST_NEUR_PARALLEL(PAR),
        .PRE_NEUR_ADDR_WIDTH(10),
        .POST_NEUR_WORD_ADDR_WIDTH(8),
        .SYN_ARRAY_ADDR_WIDTH(16)
    ) u_dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_is_train(is_train),
        .i_start_update(start),
        .i_inf_req(inf_req),
        .i_inf_addr(inf_addr),
        .o_inf_gnt(inf_gnt),
        .o_ctrl_synarray_cs(syn_cs),
        .o_ctrl_synarray_we(syn_we),
        .o_ctrl_synarray_addr(syn_addr),
        .o_ctrl_grad_array_cs(grad_cs),
        .o_ctrl_grad_array_we(grad_we),
        .o_ctrl_pre_neur_addr(pre_addr),
        .o_ctrl_post_neur_word_addr(post_addr),
        .o_busy(busy),
        .o_update_done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Stand-in for ffstdp_update: any function of old word and neuron indices works.
    function automatic logic [15:0] golden(input logic [15:0] old, input int pre, input int post);
        return (old ^ salt) + 16'(pre * 8 + post + 1);
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cs"}, 32'(syn_cs), 0);
        chk({tag, "_we"}, 32'(syn_we), 0);
        chk({tag, "_addr"}, 32'(syn_addr), 0);
        chk({tag, "_gcs"}, 32'(grad_cs), 0);
        chk({tag, "_gwe"}, 32'(grad_we), 0);
        chk({tag, "_pre"}, 32'(pre_addr), 0);
        chk({tag, "_post"}, 32'(post_addr), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_gnt"}, 32'(inf_gnt), 0);
    endtask

    // Full sweep checked cycle by cycle against an expected trace built from the nested loops.
    task automatic run_sweep(input bit inf_on, input bit poke);
        step_t       q[$];
        logic [15:0] rdata;
        rdata = '0;
        for (int k = 0; k < WORDS; k++) begin
            mem[k]    = 16'(k);
            wr_cnt[k] = 0;
        end
        for (int p = 0; p < N; p++) begin
            q.push_back('{kind: 0, addr: 0, pre: p, post: 0});
            for (int w = 0; w < WPP; w++) begin
                q.push_back('{kind: 1, addr: p * WPP + w, pre: p, post: w});
                q.push_back('{kind: 2, addr: p * WPP + w, pre: p, post: w});
            end
        end
        q.push_back('{kind: 3, addr: 0, pre: 0, post: 0});

        is_train = 1'b1;
        start    = 1'b1;
        inf_req  = inf_on;
        inf_addr = 16'd5;
        #1;
        if (inf_on) chk("start_beats_inf_gnt", 32'(inf_gnt), 0);
        tick();
        start = 1'b0;
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].kind == 0) begin
                chk("pf_cs", 32'(syn_cs), 0);
                chk("pf_gcs", 32'(grad_cs), 0);
                chk("pf_pre", 32'(pre_addr), 32'(q[i].pre));
                chk("pf_busy", 32'(busy), 1);
                chk("pf_done", 32'(done), 0);
            end else if (q[i].kind == 3) begin
                chk("done_pulse_at_16", 32'(done), 1);
                chk("done_busy", 32'(busy), 0);
                chk("done_cs", 32'(syn_cs), 0);
                chk("done_gcs", 32'(grad_cs), 0);
            end else begin
                chk("upd_cs", 32'(syn_cs), 1);
                chk("upd_gcs", 32'(grad_cs), 1);
                chk("upd_we", 32'(syn_we), 32'(q[i].kind == 2));
                chk("upd_gwe", 32'(grad_we), 32'(q[i].kind == 2));
                chk("upd_addr", 32'(syn_addr), 32'(q[i].addr));
                chk("upd_pre", 32'(pre_addr), 32'(q[i].pre));
                chk("upd_post", 32'(post_addr), 32'(q[i].post));
                chk("upd_busy", 32'(busy), 1);
                chk("upd_done", 32'(done), 0);
                if (syn_cs === 1'b1 && int'(syn_addr) < WORDS) begin
                    if (syn_we === 1'b1) begin
                        mem[syn_addr] = golden(rdata, int'(pre_addr), int'(post_addr));
                        wr_cnt[syn_addr]++;
                    end else begin
                        rdata = mem[syn_addr];
                    end
                end
            end
            if (inf_on) chk("busy_inf_gnt", 32'(inf_gnt), 0);
            if (poke && i == 4) start = 1'b1;
            if (poke && i == 5) start = 1'b0;
            if (poke && i == 6) is_train = 1'b0;
            tick();
        end
        chk("post_done_busy", 32'(busy), 0);
        chk("post_done_pulse_1cyc", 32'(done), 0);
        if (inf_on) begin
            chk("after_done_gnt", 32'(inf_gnt), 1);
            chk("after_done_cs", 32'(syn_cs), 1);
            chk("after_done_we", 32'(syn_we), 0);
            chk("after_done_addr", 32'(syn_addr), 5);
        end
        inf_req  = 1'b0;
        is_train = 1'b1;
        for (int k = 0; k < WORDS; k++) begin
            chk("mem_word", 32'(mem[k]), 32'(golden(16'(k), k / WPP, k % WPP)));
            chk("mem_wr_once", 32'(wr_cnt[k]), 1);
        end
    endtask

    initial begin
        logic r;
        logic [15:0] a;
        salt     = 16'($urandom);
        rst      = 1'b1;
        is_train = 1'b0;
        start    = 1'b0;
        inf_req  = 1'b0;
        inf_addr = '0;
        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();
        tick();
        chk_all_zero("idle");

        // Random idle inference traffic: grant follows request combinationally.
        for (int i = 0; i < 10; i++) begin
            r        = 1'($urandom);
            a        = 16'($urandom);
            inf_req  = r;
            inf_addr = a;
            #1;
            chk("idle_gnt", 32'(inf_gnt), 32'(r));
            chk("idle_cs", 32'(syn_cs), 32'(r));
            chk("idle_we", 32'(syn_we), 0);
            chk("idle_addr", 32'(syn_addr), 32'(a));
            tick();
        end
        inf_req  = 1'b0;
        inf_addr = '0;

        run_sweep(1'b0, 1'b0);
        run_sweep(1'b1, 1'b0);

        // Start without training mode is ignored.
        is_train = 1'b0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            chk("notrain_busy", 32'(busy), 0);
            chk("notrain_done", 32'(done), 0);
            tick();
        end

        // Re-start mid-sweep and training drop have no effect on sweep length.
        run_sweep(1'b0, 1'b1);

        // Reset during the write cycle of pre 1, word 0 (address 2).
        is_train = 1'b1;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("pre_rst_we", 32'(syn_we), 1);
        chk("pre_rst_addr", 32'(syn_addr), 2);
        rst = 1'b1;
        #1;
        chk_all_zero("mid_rst");
        tick();
        rst = 1'b0;
        tick();
        run_sweep(1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
